// File: rtl/uart_pkg.sv
// Shared types and helpers for the framed UART transmitter.
// The PARITY state is always enumerated; it is only reachable when UART_TX_PARITY_EN is defined.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   localparam logic IDLE_LEVEL  = 1'b1;
   localparam logic START_LEVEL = 1'b0;

   function automatic int div_w(input int clks);
      return $clog2(clks) + 1;
   endfunction

   // Counter width that never collapses to zero bits.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period divider: bit_end pulses in the last clock of each serial bit.
// restart holds the count at zero so a new frame always begins on a fresh bit.
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 1
) (
   input  logic CLK,
   input  logic RESET,
   input  logic restart,
   output logic bit_end
);

   generate
      if (CLKS_PER_BIT == 1) begin : g_nodiv
         logic unused_ok;
         assign unused_ok = ^{CLK, RESET, restart};
         assign bit_end   = 1'b1;
      end else begin : g_div
         localparam int DIV_W = div_w(CLKS_PER_BIT);
         localparam logic [DIV_W-1:0] LAST = DIV_W'(CLKS_PER_BIT - 1);

         logic [DIV_W-1:0] div_cnt;

         always_ff @(posedge CLK or posedge RESET) begin
            if (RESET) begin
               div_cnt <= '0;
            end else if (restart || (div_cnt == LAST)) begin
               div_cnt <= '0;
            end else begin
               div_cnt <= div_cnt + 1'b1;
            end
         end

         assign bit_end = (div_cnt == LAST);
      end
   endgenerate

endmodule

// File: rtl/uart_tx_framed.sv
// Framed UART transmitter: start, DATA_W data bits, optional parity, STOP_BITS stop bits.
// Define UART_TX_PARITY_EN to insert the parity bit after the data bits.
module uart_tx_framed
   import uart_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 1,
   parameter int STOP_BITS    = 1,
   parameter int MSB_FIRST    = 1,
   parameter int ODD_PARITY   = 0
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [DATA_W-1:0] data,
   input  logic              valid,
   output logic              ready,
   output logic              tx,
   output logic              busy
);

   localparam int BIT_W = cnt_w(DATA_W);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
   localparam logic LAST_STOP = 1'(STOP_BITS - 1);

   state_t            state_q, state_d;
   logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic              stop_cnt_q, stop_cnt_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic              tx_q, tx_d;
   logic              bit_end, last_stop, accept;
`ifdef UART_TX_PARITY_EN
   logic              par_q, par_d;
`else
   localparam logic unused_odd = 1'(ODD_PARITY);
`endif

   function automatic logic lead_bit(input logic [DATA_W-1:0] s);
      return (MSB_FIRST != 0) ? s[DATA_W-1] : s[0];
   endfunction

   function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] s);
      return (MSB_FIRST != 0) ? (s << 1) : (s >> 1);
   endfunction

   // Ready in the last stop clock lets a held valid start the next frame with no idle gap.
   assign last_stop = (state_q == STOP) && bit_end && (stop_cnt_q == LAST_STOP);
   assign ready     = (state_q == IDLE) || last_stop;
   assign accept    = valid && ready;
   assign busy      = (state_q != IDLE);
   assign tx        = tx_q;

   uart_baud_tick #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .CLK     (CLK),
      .RESET   (RESET),
      .restart ((state_q == IDLE) || accept),
      .bit_end (bit_end)
   );

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      stop_cnt_d = stop_cnt_q;
      shift_d    = shift_q;
      tx_d       = tx_q;
`ifdef UART_TX_PARITY_EN
      par_d      = par_q;
`endif
      case (state_q)
         START: if (bit_end) begin
            state_d   = DATA;
            bit_cnt_d = '0;
            tx_d      = lead_bit(shift_q);
         end
         DATA: if (bit_end) begin
            if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
               state_d    = PARITY;
               tx_d       = par_q;
`else
               state_d    = STOP;
               stop_cnt_d = 1'b0;
               tx_d       = IDLE_LEVEL;
`endif
            end else begin
               bit_cnt_d = bit_cnt_q + 1'b1;
               shift_d   = advance(shift_q);
               tx_d      = lead_bit(advance(shift_q));
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: if (bit_end) begin
            state_d    = STOP;
            stop_cnt_d = 1'b0;
            tx_d       = IDLE_LEVEL;
         end
`endif
         STOP: if (bit_end) begin
            if (stop_cnt_q == LAST_STOP) begin
               state_d = IDLE;
               tx_d    = IDLE_LEVEL;
            end else begin
               stop_cnt_d = stop_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = IDLE_LEVEL;
         end
      endcase
      if (accept) begin
         state_d    = START;
         shift_d    = data;
         bit_cnt_d  = '0;
         stop_cnt_d = 1'b0;
         tx_d       = START_LEVEL;
`ifdef UART_TX_PARITY_EN
         par_d      = (^data) ^ 1'(ODD_PARITY);
`endif
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q    <= IDLE;
         bit_cnt_q  <= '0;
         stop_cnt_q <= 1'b0;
         shift_q    <= '0;
         tx_q       <= IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
         par_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         stop_cnt_q <= stop_cnt_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
`ifdef UART_TX_PARITY_EN
         par_q      <= par_d;
`endif
      end
   end

endmodule

// File: tb/tb_uart_tx_framed.sv
// Directed bench for uart_tx_framed over four parameter sets; parity-aware when
// UART_TX_PARITY_EN is defined.
module tb_uart_tx_framed;

`ifdef UART_TX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif

   // clock / reset
   logic CLK = 1'b0;
   logic RESET;
   always #5 CLK = ~CLK;

   logic [7:0] data_v [4];
   logic [3:0] valid, ready, tx, busy;

   int n_checks = 0;
   int n_errors = 0;
   int acc2     = 0;

   logic [0:0] exp_q [$];

   uart_tx_framed #(.CLKS_PER_BIT(4)) u0 (
      .CLK(CLK), .RESET(RESET), .data(data_v[0]), .valid(valid[0]),
      .ready(ready[0]), .tx(tx[0]), .busy(busy[0]));
   uart_tx_framed #(.CLKS_PER_BIT(1), .MSB_FIRST(0)) u1 (
      .CLK(CLK), .RESET(RESET), .data(data_v[1]), .valid(valid[1]),
      .ready(ready[1]), .tx(tx[1]), .busy(busy[1]));
   uart_tx_framed #(.CLKS_PER_BIT(2), .STOP_BITS(2)) u2 (
      .CLK(CLK), .RESET(RESET), .data(data_v[2]), .valid(valid[2]),
      .ready(ready[2]), .tx(tx[2]), .busy(busy[2]));
   uart_tx_framed #(.CLKS_PER_BIT(1), .ODD_PARITY(1)) u3 (
      .CLK(CLK), .RESET(RESET), .data(data_v[3]), .valid(valid[3]),
      .ready(ready[3]), .tx(tx[3]), .busy(busy[3]));

   always @(posedge CLK) begin
      if (!RESET && valid[2] && ready[2]) acc2++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // expected tx level for every clock of one frame
   task automatic push_frame(input logic [7:0] d, input bit msb, input int clks,
                             input int stops, input bit odd);
      logic v;
      repeat (clks) exp_q.push_back(1'b0);
      for (int b = 0; b < 8; b++) begin
         v = msb ? d[7-b] : d[b];
         repeat (clks) exp_q.push_back(v);
      end
      if (P == 1) repeat (clks) exp_q.push_back((^d) ^ odd);
      repeat (stops * clks) exp_q.push_back(1'b1);
   endtask

   task automatic start_frame(input int k, input logic [7:0] d, input string name);
      @(negedge CLK);
      data_v[k] = d;
      valid[k]  = 1'b1;
      check({name, "_ready_idle"}, ready[k], 1);
   endtask

   // Cycle i=1 is the first clock after the accepting edge.
   task automatic run_frame(input int k, input int drop, input logic [7:0] d2,
                            input int inj, input string name);
      int len;
      len = exp_q.size();
      for (int i = 1; i <= len; i++) begin
         @(negedge CLK);
         check($sformatf("%s_tx_c%0d", name, i), tx[k], exp_q.pop_front());
         if (i == 1) data_v[k] = d2;
         if (i == drop) valid[k] = 1'b0;
         if (inj > 0 && i == inj + 1) valid[k] = 1'b0;
         if (i == inj) begin
            check({name, "_ready_busy"}, ready[k], 0);
            valid[k]  = 1'b1;
            data_v[k] = 8'h55;
         end
         if (i == len - 1) check({name, "_ready_prelast"}, ready[k], 0);
         if (i == len) check({name, "_ready_last"}, ready[k], 1);
      end
      @(negedge CLK);
      check({name, "_busy_after"}, busy[k], 0);
      check({name, "_tx_after"}, tx[k], 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int flen;
      RESET = 1'b1;
      valid = 4'h0;
      for (int k = 0; k < 4; k++) data_v[k] = 8'h00;

      for (int c = 0; c < 3; c++) begin
         @(negedge CLK);
         check($sformatf("rst_tx_%0d", c), tx, 4'hF);
         check($sformatf("rst_busy_%0d", c), busy, 4'h0);
         check($sformatf("rst_ready_%0d", c), ready, 4'hF);
      end
      RESET = 1'b0;
      @(negedge CLK);
      check("idle_tx", tx, 4'hF);
      check("idle_ready", ready, 4'hF);

      // MSB first, 4 clocks per bit, with a busy-time valid pulse at cycle 10
      push_frame(8'hB4, 1'b1, 4, 1, 1'b0);
      start_frame(0, 8'hB4, "msb");
      run_frame(0, 1, 8'h00, 10, "msb");

      // LSB first, 1 clock per bit (even parity 0, then 1)
      push_frame(8'hB4, 1'b0, 1, 1, 1'b0);
      start_frame(1, 8'hB4, "lsb_b4");
      run_frame(1, 1, 8'hFF, 0, "lsb_b4");
      push_frame(8'h07, 1'b0, 1, 1, 1'b0);
      start_frame(1, 8'h07, "lsb_07");
      run_frame(1, 1, 8'h00, 0, "lsb_07");

      // odd parity instance
      push_frame(8'hB4, 1'b1, 1, 1, 1'b1);
      start_frame(3, 8'hB4, "odd_b4");
      run_frame(3, 1, 8'h00, 0, "odd_b4");

      // back-to-back with valid held through both accepts
      flen = (1 + 8 + P + 2) * 2;
      push_frame(8'h00, 1'b1, 2, 2, 1'b0);
      push_frame(8'hFF, 1'b1, 2, 2, 1'b0);
      start_frame(2, 8'h00, "b2b");
      run_frame(2, flen + 1, 8'hFF, 0, "b2b");
      check("b2b_accepts", acc2, 2);

      // reset asserted during the start bit
      start_frame(0, 8'hA5, "rst_mid");
      @(negedge CLK);
      valid[0] = 1'b0;
      @(negedge CLK);
      check("rst_mid_pre_tx", tx[0], 0);
      check("rst_mid_pre_busy", busy[0], 1);
      RESET = 1'b1;
      #1;
      check("rst_mid_tx", tx[0], 1);
      check("rst_mid_busy", busy[0], 0);
      @(negedge CLK);
      RESET = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge CLK);
         check($sformatf("rst_mid_post_tx_%0d", c), tx[0], 1);
         check($sformatf("rst_mid_post_busy_%0d", c), busy[0], 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
